uart_tx: RTL

- 8N1 UART transmitter: takes parallel bytes from upstream logic and serialises them onto the TX line at a fixed baud rate.
- It is the transmit counterpart of the team's UART receiver and uses the same clock (25 MHz PLL output) and the same cycles-per-bit convention.
- A one-entry holding register lets upstream queue the next byte while the current frame is shifting, so frames go out back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter with a one-entry holding register.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int c_CYCLES_PER_BIT = 217
) (
    input  logic       i_CLK,
    input  logic       i_RESET_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_BYTE,
    output logic       o_TX_READY,
    output logic       o_TX_SERIAL,
    output logic       o_TX_ACTIVE,
    output logic       o_TX_DONE
);

    localparam int                 c_CNT_W   = (c_CYCLES_PER_BIT > 1) ? $clog2(c_CYCLES_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [c_CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]         idx_q,      idx_d;
    logic [7:0]         shift_q,    shift_d;
    logic [7:0]         hold_q,     hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               ready_q,    ready_d;
    logic               serial_q,   serial_d;
    logic               active_q,   active_d;
    logic               done_q,     done_d;

    logic w_accept;
    logic w_bit_end;

    assign w_accept  = i_TX_DV & ready_q;
    assign w_bit_end = (cnt_q == c_CNT_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (w_accept) begin
                    shift_d = i_TX_BYTE;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    // Queued byte wins; otherwise a same-cycle accept skips holding.
                    if (hold_vld_q) begin
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        state_d    = S_START;
                    end else if (w_accept) begin
                        shift_d = i_TX_BYTE;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase

        if (w_accept && (state_q != S_IDLE) && !((state_q == S_STOP) && w_bit_end)) begin
            hold_d     = i_TX_BYTE;
            hold_vld_d = 1'b1;
        end

        // Outputs are precomputed from next state so every port comes from a flop.
        ready_d  = ~hold_vld_d;
        active_d = (state_d != S_IDLE);
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[idx_d];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            hold_q     <= 8'd0;
            hold_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ready_q    <= ready_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign o_TX_READY  = ready_q;
    assign o_TX_SERIAL = serial_q;
    assign o_TX_ACTIVE = active_q;
    assign o_TX_DONE   = done_q;

endmodule
`default_nettype wire
